// File: rtl/lb_pattern_checker_if.sv
// Bus between the RX PCS byte stream and the loopback pattern checker.
// rx_valid_i alone qualifies a beat; the checker never stalls, so there is no ready.
interface lb_pattern_checker_if #(
  parameter int BYTES = 2,
  parameter int CNT_W = 16
);
  logic                 rx_valid_i;
  logic [8*BYTES-1:0]   rx_data_i;
  logic [BYTES-1:0]     rx_k_i;
  logic                 cnt_clr_i;
  logic                 locked_o;
  logic                 err_o;
  logic [CNT_W-1:0]     err_cnt_o;
  logic [31:0]          beat_cnt_o;
  logic [2:0]           phase_o;
  logic [1:0]           state_o;

  modport master (
    output rx_valid_i, rx_data_i, rx_k_i, cnt_clr_i,
    input  locked_o, err_o, err_cnt_o, beat_cnt_o, phase_o, state_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, rx_k_i, cnt_clr_i,
    output locked_o, err_o, err_cnt_o, beat_cnt_o, phase_o, state_o
  );
endinterface

// File: rtl/lb_pattern_checker.sv
// Loopback RX pattern checker: aligns to the comma or count test frame,
// tracks lock, and counts mismatching bytes and beats while locked.
module lb_pattern_checker #(
  parameter int BYTES       = 2,
  parameter bit COMMA_MODE  = 1'b1,
  parameter int LOCK_BEATS  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst_i,
  lb_pattern_checker_if.slave  bus
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [2:0] PH_STEP = 3'(BYTES);

  logic [1:0]       state;
  logic [2:0]       phase;
  logic [7:0]       good_run;
  logic [3:0]       bad_run;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt;
  logic [31:0]      beat_cnt;

  // Expected {K, data} at a frame position.
  function automatic logic [8:0] exp_sym(input logic [2:0] p);
    if (COMMA_MODE)
      exp_sym = (p == 3'd0) ? {1'b1, 8'hBC} : {1'b0, 8'h4A};
    else
      exp_sym = {1'b0, 5'd0, p} + 9'd1;
  endfunction

  logic [8:0]       ref_sym;
  logic             hit;
  logic [2:0]       hit_lane;
  logic [2:0]       cand_ph;
  logic [BYTES-1:0] mis;
  logic [BYTES-1:0] hunt_mis;
  logic [3:0]       n_mis;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    ref_sym  = exp_sym(3'd0);
    hit      = 1'b0;
    hit_lane = 3'd0;
    // Walk downwards so the lowest matching lane wins.
    for (int i = BYTES - 1; i >= 0; i--) begin
      if ({bus.rx_k_i[i], bus.rx_data_i[8*i +: 8]} == ref_sym) begin
        hit      = 1'b1;
        hit_lane = 3'(i);
      end
    end
    cand_ph  = 3'd0 - hit_lane;
    mis      = '0;
    hunt_mis = '0;
    n_mis    = 4'd0;
    for (int i = 0; i < BYTES; i++) begin
      mis[i]      = {bus.rx_k_i[i], bus.rx_data_i[8*i +: 8]} != exp_sym(phase + 3'(i));
      hunt_mis[i] = {bus.rx_k_i[i], bus.rx_data_i[8*i +: 8]} != exp_sym(cand_ph + 3'(i));
      n_mis       = n_mis + {3'd0, mis[i]};
    end
    err_sum = {1'b0, err_cnt} + (CNT_W+1)'(n_mis);
  end

  always_ff @(posedge rx_clk or posedge rx_rst_i) begin
    if (rx_rst_i) begin
      state    <= HUNT;
      phase    <= 3'd0;
      good_run <= 8'd0;
      bad_run  <= 4'd0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
      beat_cnt <= 32'd0;
    end else begin
      err_q <= 1'b0;
      if (bus.rx_valid_i) begin
        case (state)
          HUNT: begin
            if (hit && (hunt_mis == '0)) begin
              phase    <= cand_ph + PH_STEP;
              good_run <= 8'd1;
              state    <= (LOCK_BEATS == 1) ? LOCKED : CHECK;
            end
          end
          CHECK: begin
            phase <= phase + PH_STEP;
            if (mis == '0) begin
              good_run <= good_run + 8'd1;
              if (good_run == 8'(LOCK_BEATS - 1))
                state <= LOCKED;
            end else begin
              good_run <= 8'd0;
              state    <= HUNT;
            end
          end
          LOCKED: begin
            phase <= phase + PH_STEP;
            if (beat_cnt != 32'hFFFF_FFFF)
              beat_cnt <= beat_cnt + 32'd1;
            if (mis == '0) begin
              bad_run <= 4'd0;
            end else begin
              err_q   <= 1'b1;
              err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
              if (bad_run == 4'(UNLOCK_ERRS - 1)) begin
                bad_run  <= 4'd0;
                good_run <= 8'd0;
                state    <= HUNT;
              end else begin
                bad_run <= bad_run + 4'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
      // Clear wins over any increment in the same cycle.
      if (bus.cnt_clr_i) begin
        err_cnt  <= '0;
        beat_cnt <= 32'd0;
      end
    end
  end

  assign bus.locked_o   = (state == LOCKED);
  assign bus.err_o      = err_q;
  assign bus.err_cnt_o  = err_cnt;
  assign bus.beat_cnt_o = beat_cnt;
  assign bus.phase_o    = phase;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_lb_pattern_checker.sv
// Directed bench for lb_pattern_checker: comma-mode instance (CNT_W=16) and
// count-mode instance (CNT_W=4) on one clock, checked against hand-derived values.
module tb_lb_pattern_checker;

  logic rx_clk = 1'b0;
  logic rx_rst_i;
  int   n_checks = 0;
  int   n_errors = 0;

  lb_pattern_checker_if #(.BYTES(2), .CNT_W(16)) bus_a ();
  lb_pattern_checker_if #(.BYTES(2), .CNT_W(4))  bus_b ();

  lb_pattern_checker #(
    .BYTES(2), .COMMA_MODE(1'b1), .LOCK_BEATS(16), .UNLOCK_ERRS(4), .CNT_W(16)
  ) dut_a (
    .rx_clk   (rx_clk),
    .rx_rst_i (rx_rst_i),
    .bus      (bus_a.slave)
  );

  lb_pattern_checker #(
    .BYTES(2), .COMMA_MODE(1'b0), .LOCK_BEATS(16), .UNLOCK_ERRS(4), .CNT_W(4)
  ) dut_b (
    .rx_clk   (rx_clk),
    .rx_rst_i (rx_rst_i),
    .bus      (bus_b.slave)
  );

  // clock / reset
  always #5 rx_clk = ~rx_clk;

  // stream tables (frame starting at position 0 and at position 7)
  logic [15:0] comma_d [4] = '{16'h4ABC, 16'h4A4A, 16'h4A4A, 16'h4A4A};
  logic [1:0]  comma_k [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
  logic [15:0] off_d   [4] = '{16'hBC4A, 16'h4A4A, 16'h4A4A, 16'h4A4A};
  logic [1:0]  off_k   [4] = '{2'b10, 2'b00, 2'b00, 2'b00};
  logic [15:0] cnt_d   [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change #1 after a rising edge, outputs sampled there too
  task automatic beat_a(input logic [15:0] d, input logic [1:0] k);
    bus_a.rx_valid_i = 1'b1;
    bus_a.rx_data_i  = d;
    bus_a.rx_k_i     = k;
    @(posedge rx_clk); #1;
    bus_a.rx_valid_i = 1'b0;
    bus_a.cnt_clr_i  = 1'b0;
  endtask

  task automatic beat_b(input logic [15:0] d, input logic [1:0] k);
    bus_b.rx_valid_i = 1'b1;
    bus_b.rx_data_i  = d;
    bus_b.rx_k_i     = k;
    @(posedge rx_clk); #1;
    bus_b.rx_valid_i = 1'b0;
    bus_b.cnt_clr_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rx_clk); #1;
    end
  endtask

  task automatic do_reset();
    rx_rst_i = 1'b1;
    idle(2);
    rx_rst_i = 1'b0;
    idle(1);
  endtask

  initial begin
    bus_a.rx_valid_i = 1'b0; bus_a.rx_data_i = '0; bus_a.rx_k_i = '0; bus_a.cnt_clr_i = 1'b0;
    bus_b.rx_valid_i = 1'b0; bus_b.rx_data_i = '0; bus_b.rx_k_i = '0; bus_b.cnt_clr_i = 1'b0;
    do_reset();

    check("rst_locked", 64'(bus_a.locked_o), 64'd0);
    check("rst_err", 64'(bus_a.err_o), 64'd0);
    check("rst_err_cnt", 64'(bus_a.err_cnt_o), 64'd0);
    check("rst_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd0);
    check("rst_phase", 64'(bus_a.phase_o), 64'd0);

    // comma lock from phase 0
    for (int n = 0; n < 16; n++) begin
      beat_a(comma_d[n % 4], comma_k[n % 4]);
      if (n < 4) check("t1_phase", 64'(bus_a.phase_o), 64'(((n + 1) * 2) % 8));
      if (n == 14) check("t1_not_locked_15", 64'(bus_a.locked_o), 64'd0);
    end
    check("t1_locked_16", 64'(bus_a.locked_o), 64'd1);
    check("t1_err_cnt", 64'(bus_a.err_cnt_o), 64'd0);
    check("t1_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd0);

    // single corrupted byte while locked
    beat_a(16'h4ABC, 2'b01);
    check("t3_beat_cnt_pre", 64'(bus_a.beat_cnt_o), 64'd1);
    beat_a(16'h4A4B, 2'b00);
    check("t3_err_pulse", 64'(bus_a.err_o), 64'd1);
    check("t3_err_cnt", 64'(bus_a.err_cnt_o), 64'd1);
    check("t3_locked", 64'(bus_a.locked_o), 64'd1);
    check("t3_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd2);
    beat_a(16'h4A4A, 2'b00);
    check("t3_err_one_cycle", 64'(bus_a.err_o), 64'd0);
    check("t3_phase", 64'(bus_a.phase_o), 64'd6);

    // idle clear, then four all-bad beats drop lock
    bus_a.cnt_clr_i = 1'b1;
    idle(1);
    bus_a.cnt_clr_i = 1'b0;
    check("t4_clr_err_cnt", 64'(bus_a.err_cnt_o), 64'd0);
    check("t4_clr_locked", 64'(bus_a.locked_o), 64'd1);
    for (int n = 0; n < 4; n++) begin
      beat_a(16'h0000, 2'b00);
      if (n == 2) check("t4_locked_after_3", 64'(bus_a.locked_o), 64'd1);
    end
    check("t4_unlocked", 64'(bus_a.locked_o), 64'd0);
    check("t4_err_cnt", 64'(bus_a.err_cnt_o), 64'd8);
    check("t4_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd4);
    check("t4_phase", 64'(bus_a.phase_o), 64'd6);
    for (int n = 0; n < 16; n++) begin
      beat_a(comma_d[n % 4], comma_k[n % 4]);
      if (n == 0) check("t4_hunt_realign", 64'(bus_a.phase_o), 64'd2);
      if (n == 14) check("t4_relock_15", 64'(bus_a.locked_o), 64'd0);
    end
    check("t4_relocked", 64'(bus_a.locked_o), 64'd1);
    check("t4_cnt_kept", 64'(bus_a.err_cnt_o), 64'd8);

    // hold with rx_valid_i low
    idle(10);
    check("t6_hold_locked", 64'(bus_a.locked_o), 64'd1);
    check("t6_hold_phase", 64'(bus_a.phase_o), 64'd0);
    check("t6_hold_err_cnt", 64'(bus_a.err_cnt_o), 64'd8);
    check("t6_hold_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd4);
    check("t6_hold_err", 64'(bus_a.err_o), 64'd0);

    // clear coincident with a bad beat
    bus_a.cnt_clr_i = 1'b1;
    beat_a(16'h0000, 2'b00);
    check("t6_clr_err_pulse", 64'(bus_a.err_o), 64'd1);
    check("t6_clr_err_cnt", 64'(bus_a.err_cnt_o), 64'd0);
    check("t6_clr_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd0);
    check("t6_clr_locked", 64'(bus_a.locked_o), 64'd1);
    beat_a(16'h4A4A, 2'b00);
    beat_a(16'h4A00, 2'b00);
    check("t6_pre_rst_err_cnt", 64'(bus_a.err_cnt_o), 64'd1);
    check("t6_pre_rst_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd2);

    // asynchronous reset between edges
    #2 rx_rst_i = 1'b1;
    #1;
    check("t6_async_locked", 64'(bus_a.locked_o), 64'd0);
    check("t6_async_err", 64'(bus_a.err_o), 64'd0);
    check("t6_async_err_cnt", 64'(bus_a.err_cnt_o), 64'd0);
    check("t6_async_beat_cnt", 64'(bus_a.beat_cnt_o), 64'd0);
    check("t6_async_phase", 64'(bus_a.phase_o), 64'd0);
    idle(1);
    rx_rst_i = 1'b0;
    idle(1);

    // hunt: no reference byte leaves phase alone, then offset comma at lane 1
    beat_a(16'h4A4A, 2'b00);
    check("t2_nohit_locked", 64'(bus_a.locked_o), 64'd0);
    check("t2_nohit_phase", 64'(bus_a.phase_o), 64'd0);
    for (int n = 0; n < 16; n++) begin
      beat_a(off_d[n % 4], off_k[n % 4]);
      if (n == 0) check("t2_cand_phase", 64'(bus_a.phase_o), 64'd1);
      if (n == 14) check("t2_not_locked_15", 64'(bus_a.locked_o), 64'd0);
    end
    check("t2_locked", 64'(bus_a.locked_o), 64'd1);
    check("t2_err_cnt", 64'(bus_a.err_cnt_o), 64'd0);

    // count mode lock, K-flag error, saturation at 15
    for (int n = 0; n < 16; n++) beat_b(cnt_d[n % 4], 2'b00);
    check("t5_locked", 64'(bus_b.locked_o), 64'd1);
    check("t5_phase", 64'(bus_b.phase_o), 64'd0);
    beat_b(16'h0201, 2'b01);
    check("t5_kflag_err", 64'(bus_b.err_cnt_o), 64'd1);
    check("t5_kflag_pulse", 64'(bus_b.err_o), 64'd1);
    begin
      int idx;
      idx = 1;
      for (int n = 0; n < 20; n++) begin
        beat_b(16'h0000, 2'b00);
        idx = (idx + 1) % 4;
        if (n == 5) check("t5_err_cnt_13", 64'(bus_b.err_cnt_o), 64'd13);
        if (n == 6) check("t5_err_cnt_15", 64'(bus_b.err_cnt_o), 64'd15);
        if (n == 7) check("t5_clamp", 64'(bus_b.err_cnt_o), 64'd15);
        beat_b(cnt_d[idx], 2'b00);
        idx = (idx + 1) % 4;
      end
    end
    check("t5_sat_final", 64'(bus_b.err_cnt_o), 64'd15);
    check("t5_still_locked", 64'(bus_b.locked_o), 64'd1);
    check("t5_beat_cnt", 64'(bus_b.beat_cnt_o), 64'd41);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lb_pattern_checker.md
Name: lb_pattern_checker

Overview:
Receive-side checker that sits directly downstream of the SerDes RX PCS in the loopback bench. It consumes 8b/10b-decoded bytes and K flags on the recovered RX clock, and aligns to the fixed loopback test stream: either comma mode (K28.5 followed by filler 0x4A) or count mode (0x01..0x08). It reports lock status, per-beat error pulses and saturating error and beat counters, so loopback health is visible without a logic analyser.

Parameters:
BYTES, 2, byte lanes per beat. Legal values: 1, 2, 4, 8. Lane 0 is the LSB byte and is the earliest byte in the stream.
COMMA_MODE, 1, 1 = 8-byte frame is BC(K) then seven 4A(D); 0 = frame is 01..08, all D.
LOCK_BEATS, 16, consecutive error-free beats needed to declare lock (1..255).
UNLOCK_ERRS, 4, consecutive erroneous beats while locked that drop lock (1..15).
CNT_W, 16, width of err_cnt_o.

Ports:
rx_clk  in  1  recovered RX clock (SerDes RX_CLK_O); the only clock.
rx_rst_i  in  1  asynchronous, active-high reset.
rx_valid_i  in  1  qualifies rx_data_i/rx_k_i this cycle.
rx_data_i  in  8*BYTES  decoded RX bytes.
rx_k_i  in  BYTES  per-lane K-character flag.
cnt_clr_i  in  1  synchronous clear of err_cnt_o and beat_cnt_o.
locked_o  out  1  checker is aligned and locked.
err_o  out  1  one-cycle pulse: the previous valid beat had at least one byte mismatch while LOCKED.
err_cnt_o  out  CNT_W  saturating count of mismatching bytes while LOCKED.
beat_cnt_o  out  32  saturating count of valid beats while LOCKED.
phase_o  out  3  frame position expected for lane 0 of the next beat.

Behaviour:
- Reset (async assert, sync release): state HUNT, phase 0, every output 0, internal run counters 0.
- Expected byte at frame position p (0..7):
  - COMMA_MODE=1: p=0 gives 0xBC with K=1; otherwise 0x4A with K=0.
  - COMMA_MODE=0: the value is p+1 with K=0.
- A byte matches only if both its data and its K flag are equal to the expected values.
- Lane i of a beat checked at phase ph has expected position (ph+i) mod 8.
- After each valid beat, phase advances by BYTES mod 8 in every state. In HUNT, phase is first reloaded from the hit (see below).
- rx_valid_i=0: no state, phase or counter change; err_o=0.
- FSM (all transitions on valid beats only):
  - HUNT:
    - Find the lowest lane i holding the position-0 reference byte (BC/K in comma mode, 01/D in count mode).
    - Candidate ph = (8-i) mod 8. Compare the full beat at ph.
    - All lanes match: go to CHECK, good_run=1, phase = ph+BYTES.
    - Otherwise, or no reference byte present: stay in HUNT, phase unchanged.
  - CHECK:
    - Full match: good_run++. When good_run reaches LOCK_BEATS, go to LOCKED.
    - Any mismatch: go to HUNT, good_run=0.
    - If LOCK_BEATS=1, go directly from HUNT to LOCKED.
  - LOCKED:
    - Full match: bad_run=0, beat_cnt++.
    - Mismatch: err_o=1 next cycle, err_cnt += number of mismatching lanes, bad_run++, beat_cnt++.
    - When bad_run reaches UNLOCK_ERRS, go to HUNT and clear bad_run.
    - No realignment while locked; phase keeps free-running.
- Latency: all outputs are registered and update in the cycle after the beat is sampled.
  - locked_o rises one cycle after the LOCK_BEATS-th good beat.
  - locked_o falls one cycle after the UNLOCK_ERRS-th bad beat.
- Saturation:
  - err_cnt_o holds at 2^CNT_W-1. A multi-byte addition that would overflow clamps to max.
  - beat_cnt_o holds at 2^32-1.
- cnt_clr_i has priority over increments in the same cycle: counters read 0 next cycle. err_o still pulses for a coincident bad beat; locked_o and the FSM are unaffected.
- Counters are not cleared on loss of lock; only reset or cnt_clr_i clears them.
- Reset asserted mid-LOCKED: outputs go to 0 immediately, without waiting for an rx_clk edge.

Test Plan:
1. Comma mode, BYTES=2: repeat beats 16'h4ABC/k=01, then 16'h4A4A/k=00 three times. locked_o=1 one cycle after the 16th beat; err_cnt_o=0; phase_o sequence 2,4,6,0.
2. Offset comma: first beat 16'hBC4A/k=10, then the correctly continued stream. Candidate phase 7, lock after 16 beats, no errors.
3. Locked, inject one beat 16'h4A4B/k=00 at phase 2: single err_o pulse, err_cnt_o=1, locked_o stays 1, beat_cnt_o increments.
4. Locked, four consecutive beats 16'h0000/k=00: err_cnt_o=8, locked_o falls after the 4th beat. A valid stream then relocks after 16 further beats.
5. Count mode, BYTES=2: 16'h0201, 0403, 0605, 0807 repeating gives lock. Then 16'h0201 with k=01 gives err_cnt_o+1. With CNT_W=4 and 20 all-bad beats held below UNLOCK_ERRS via interleaved good beats, err_cnt_o saturates at 15.
6. Locked, hold rx_valid_i=0 for 10 cycles: outputs and phase_o hold. Pulse cnt_clr_i together with a bad beat: counters read 0 and err_o=1. Assert rx_rst_i between clock edges: all outputs 0 immediately.
